// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared unit codes, slot states and counter width for execute dispatch
package ex_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    FU_NONE = 2'b00,
    FU_ALU  = 2'b01,
    FU_MEM  = 2'b10,
    FU_MUL  = 2'b11
  } fu_code_e;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'b00,
    SLOT_RUN  = 2'b01,
    SLOT_DONE = 2'b10
  } slot_state_e;

endpackage

// File: rtl/ex_fu_dispatch_fu_slot.sv
// rtl/ex_fu_dispatch_fu_slot.sv - one functional-unit occupancy slot: state, latency counter, tag
module fu_slot
  import ex_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       accept_i,
  input  logic [4:0] regdest_i,
  input  logic       writereg_i,
  input  logic       grant_i,
  output logic       req_o,
  output logic       can_accept_o,
  output logic       busy_o,
  output logic [4:0] regdest_o
);

  slot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       tag_q, tag_d;
  logic             wr_q, wr_d;
  logic             finishing;

  assign finishing    = (state_q == SLOT_RUN) && (cnt_q == '0);
  assign req_o        = (finishing && wr_q) || (state_q == SLOT_DONE);
  // A slot can be refilled in the same cycle it retires, either by grant or a silent store.
  assign can_accept_o = (state_q == SLOT_IDLE) || grant_i || (finishing && !wr_q);
  assign busy_o       = (state_q != SLOT_IDLE);
  assign regdest_o    = tag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    wr_d    = wr_q;
    if (accept_i) begin
      state_d = SLOT_RUN;
      cnt_d   = CNT_W'(LAT - 1);
      tag_d   = regdest_i;
      wr_d    = writereg_i;
    end else begin
      case (state_q)
        SLOT_RUN: begin
          if (cnt_q == '0) begin
            if (!wr_q || grant_i) state_d = SLOT_IDLE;
            else                  state_d = SLOT_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SLOT_DONE: if (grant_i) state_d = SLOT_IDLE;
        default:   state_d = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SLOT_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: rtl/ex_fu_dispatch.sv
// rtl/ex_fu_dispatch.sv - execute-side unit occupancy, issue stall and single-port writeback arbiter
module ex_fu_dispatch
  import ex_pkg::*;
#(
  parameter int LAT_ALU = 1,
  parameter int LAT_MEM = 2,
  parameter int LAT_MUL = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] is_ex_unidadefuncional,
  input  logic [4:0] is_ex_regdest,
  input  logic       is_ex_writereg,
  output logic       execute_stall,
  output logic [2:0] ex_fu_start,
  output logic [2:0] ex_fu_busy,
  output logic       ex_wb_valid,
  output logic [4:0] ex_wb_regdest,
  output logic [1:0] ex_wb_unit
);

  logic [2:0] sel, accept, req, grant, can_accept;
  logic [4:0] slot_tag [3];
  logic [2:0] start_q;

  // Bit order everywhere: [0] ALU, [1] MEM, [2] MUL.
  assign sel[0] = (is_ex_unidadefuncional == FU_ALU);
  assign sel[1] = (is_ex_unidadefuncional == FU_MEM);
  assign sel[2] = (is_ex_unidadefuncional == FU_MUL);

  assign accept        = sel & can_accept;
  assign execute_stall = (|sel) && !(|accept);

  // Fixed priority MEM > MUL > ALU.
  always_comb begin
    grant         = 3'b000;
    ex_wb_regdest = 5'd0;
    ex_wb_unit    = FU_NONE;
    if (req[1]) begin
      grant         = 3'b010;
      ex_wb_regdest = slot_tag[1];
      ex_wb_unit    = FU_MEM;
    end else if (req[2]) begin
      grant         = 3'b100;
      ex_wb_regdest = slot_tag[2];
      ex_wb_unit    = FU_MUL;
    end else if (req[0]) begin
      grant         = 3'b001;
      ex_wb_regdest = slot_tag[0];
      ex_wb_unit    = FU_ALU;
    end
  end

  assign ex_wb_valid = |req;
  assign ex_fu_start = start_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) start_q <= 3'b000;
    else       start_q <= accept;
  end

  fu_slot #(.LAT(LAT_ALU)) u_alu (
    .clk_i(clock), .rst_i(reset), .accept_i(accept[0]), .regdest_i(is_ex_regdest),
    .writereg_i(is_ex_writereg), .grant_i(grant[0]), .req_o(req[0]),
    .can_accept_o(can_accept[0]), .busy_o(ex_fu_busy[0]), .regdest_o(slot_tag[0])
  );

  fu_slot #(.LAT(LAT_MEM)) u_mem (
    .clk_i(clock), .rst_i(reset), .accept_i(accept[1]), .regdest_i(is_ex_regdest),
    .writereg_i(is_ex_writereg), .grant_i(grant[1]), .req_o(req[1]),
    .can_accept_o(can_accept[1]), .busy_o(ex_fu_busy[1]), .regdest_o(slot_tag[1])
  );

  fu_slot #(.LAT(LAT_MUL)) u_mul (
    .clk_i(clock), .rst_i(reset), .accept_i(accept[2]), .regdest_i(is_ex_regdest),
    .writereg_i(is_ex_writereg), .grant_i(grant[2]), .req_o(req[2]),
    .can_accept_o(can_accept[2]), .busy_o(ex_fu_busy[2]), .regdest_o(slot_tag[2])
  );

endmodule

// File: tb/tb_ex_fu_dispatch.sv
// tb/tb_ex_fu_dispatch.sv - scoreboard bench for ex_fu_dispatch
module tb_ex_fu_dispatch;

  logic       clock;
  logic       reset;
  logic [1:0] is_ex_unidadefuncional;
  logic [4:0] is_ex_regdest;
  logic       is_ex_writereg;
  logic       execute_stall;
  logic [2:0] ex_fu_start;
  logic [2:0] ex_fu_busy;
  logic       ex_wb_valid;
  logic [4:0] ex_wb_regdest;
  logic [1:0] ex_wb_unit;

  typedef struct {
    int rd;
    int unit;
    int cyc;
  } wb_exp_t;

  wb_exp_t    sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         t0;
  logic [2:0] exp_start = 3'b000;

  ex_fu_dispatch dut (
    .clock(clock), .reset(reset),
    .is_ex_unidadefuncional(is_ex_unidadefuncional),
    .is_ex_regdest(is_ex_regdest), .is_ex_writereg(is_ex_writereg),
    .execute_stall(execute_stall), .ex_fu_start(ex_fu_start), .ex_fu_busy(ex_fu_busy),
    .ex_wb_valid(ex_wb_valid), .ex_wb_regdest(ex_wb_regdest), .ex_wb_unit(ex_wb_unit)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] code);
    case (code)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic void push(input int rd, input int unit, input int at);
    wb_exp_t e;
    e.rd = rd; e.unit = unit; e.cyc = at;
    sb_q.push_back(e);
  endfunction

  // Monitor: every granted writeback must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && ex_wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wb_rd", int'(ex_wb_regdest), -1);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        chk("wb_rd", int'(ex_wb_regdest), e.rd);
        chk("wb_unit", int'(ex_wb_unit), e.unit);
        chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step(input logic [1:0] code, input logic [4:0] rd, input logic wr,
                      input logic exp_stall, input int exp_busy);
    is_ex_unidadefuncional = code;
    is_ex_regdest          = rd;
    is_ex_writereg         = wr;
    @(negedge clock);
    chk("stall", int'(execute_stall), int'(exp_stall));
    chk("start", int'(ex_fu_start), int'(exp_start));
    if (exp_busy >= 0) chk("busy", int'(ex_fu_busy), exp_busy);
    exp_start = exp_stall ? 3'b000 : onehot(code);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    reset = 1'b1;
    is_ex_unidadefuncional = 2'b00;
    is_ex_regdest = 5'd0;
    is_ex_writereg = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_wb_valid", int'(ex_wb_valid), 0);
    chk("rst_busy", int'(ex_fu_busy), 0);
    chk("rst_start", int'(ex_fu_start), 0);
    chk("rst_rd", int'(ex_wb_regdest), 0);
    reset = 1'b0;
    idle(2);

    // Single ALU op
    t0 = cyc;
    push(5, 1, t0 + 1);
    step(2'b01, 5'd5, 1'b1, 1'b0, 0);
    step(2'b00, 5'd0, 1'b0, 1'b0, 3'b001);
    idle(3);

    // Back-to-back ALU
    t0 = cyc;
    push(1, 1, t0 + 1); step(2'b01, 5'd1, 1'b1, 1'b0, -1);
    push(2, 1, t0 + 2); step(2'b01, 5'd2, 1'b1, 1'b0, 3'b001);
    push(3, 1, t0 + 3); step(2'b01, 5'd3, 1'b1, 1'b0, 3'b001);
    idle(3);

    // Busy MUL: second MUL stalls until first writes back
    t0 = cyc;
    push(7, 3, t0 + 4); step(2'b11, 5'd7, 1'b1, 1'b0, -1);
    step(2'b11, 5'd8, 1'b1, 1'b1, 3'b100);
    step(2'b11, 5'd8, 1'b1, 1'b1, -1);
    step(2'b11, 5'd8, 1'b1, 1'b1, -1);
    push(8, 3, t0 + 8); step(2'b11, 5'd8, 1'b1, 1'b0, 3'b100);
    idle(6);

    // Collision MEM vs ALU
    t0 = cyc;
    push(4, 2, t0 + 2); step(2'b10, 5'd4, 1'b1, 1'b0, -1);
    push(9, 1, t0 + 3); step(2'b01, 5'd9, 1'b1, 1'b0, 3'b010);
    step(2'b01, 5'd10, 1'b1, 1'b1, 3'b011);
    push(10, 1, t0 + 4); step(2'b01, 5'd10, 1'b1, 1'b0, 3'b001);
    idle(3);

    // Store back-to-back with a MEM load, then a lone store retiring
    t0 = cyc;
    step(2'b10, 5'd6, 1'b0, 1'b0, -1);
    step(2'b00, 5'd0, 1'b0, 1'b0, 3'b010);
    push(11, 2, t0 + 4); step(2'b10, 5'd11, 1'b1, 1'b0, 3'b010);
    idle(4);
    step(2'b10, 5'd13, 1'b0, 1'b0, 0);
    step(2'b00, 5'd0, 1'b0, 1'b0, 3'b010);
    step(2'b00, 5'd0, 1'b0, 1'b0, 3'b010);
    step(2'b00, 5'd0, 1'b0, 1'b0, 0);
    idle(2);

    // Reset while a MUL is in flight: its tag must never write back
    step(2'b11, 5'd12, 1'b1, 1'b0, -1);
    step(2'b00, 5'd0, 1'b0, 1'b0, 3'b100);
    #1 reset = 1'b1;
    #1;
    chk("midrst_wb_valid", int'(ex_wb_valid), 0);
    chk("midrst_busy", int'(ex_fu_busy), 0);
    chk("midrst_start", int'(ex_fu_start), 0);
    chk("midrst_stall", int'(execute_stall), 0);
    #1 reset = 1'b0;
    exp_start = 3'b000;
    @(posedge clock);
    #1;
    step(2'b00, 5'd0, 1'b0, 1'b0, 0);
    idle(8);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clock);
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_fu_dispatch.md
Name: ex_fu_dispatch

Overview:
- Execute-side occupancy tracker and writeback arbiter that sits directly downstream of the issue stage.
- Consumes each issued op's functional-unit code plus destination tag, starts the selected unit, and counts its latency.
- Arbitrates a single writeback port and returns execute_stall to issue when the target unit cannot accept.
- Holds tags and control only; the datapath units take the operand buses directly.

Parameters:
- LAT_ALU, 1, ALU latency in cycles (1..15).
- LAT_MEM, 2, load/store unit latency in cycles (1..15).
- LAT_MUL, 4, long-op unit latency for code 11 (1..15).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- is_ex_unidadefuncional  in  2  00 bubble, 01 ALU, 10 MEM, 11 MUL.
- is_ex_regdest  in  5  destination register tag of the issued op.
- is_ex_writereg  in  1  op writes the register file.
- execute_stall  out  1  combinational: the current issued op is not accepted and issue must hold it.
- ex_fu_start  out  3  one-hot start pulse [0] ALU, [1] MEM, [2] MUL, registered.
- ex_fu_busy  out  3  per-unit occupied flag, same bit order as ex_fu_start.
- ex_wb_valid  out  1  writeback granted this cycle.
- ex_wb_regdest  out  5  tag being written back; scoreboard clears its pending bit.
- ex_wb_unit  out  2  unit code of the granted writeback.

Behaviour:
- Reset (asynchronous, active-high) behaviour:
  - all outputs 0, all counters 0, all units idle.
  - Reset asserted mid-operation discards in-flight ops; no writeback is emitted for them.
- Per-unit state:
  - Three identical slots, each holding state IDLE / RUN / DONE plus a 4-bit counter, regdest and writereg.
- Acceptance in cycle N:
  - Condition: code != 00 and target slot is IDLE, or target slot is granted writeback in cycle N, or target slot is finishing a writereg=0 op in cycle N.
  - Effect at the end of N: slot -> RUN, counter = LAT_x - 1, tag latched.
  - ex_fu_start[x] is high during N+1.
- execute_stall:
  - Equals (code != 00) and not accept.
  - Code 00 never stalls and changes no state.
- RUN state:
  - Counter decrements each cycle.
  - At counter == 0 the slot has completed and is presented to the arbiter in that same cycle.
  - Net effect: an op issued in cycle N presents for writeback in cycle N+LAT.
- Completion with writereg = 0 (store):
  - Slot returns to IDLE without requesting writeback.
  - ex_wb_valid is not asserted for it.
- Arbiter:
  - One grant per cycle, fixed priority MEM > MUL > ALU.
  - Winner: ex_wb_valid = 1 with regdest and unit driven in that cycle; the slot frees at the end of the cycle.
  - Losers: enter DONE, keep their tag, and re-request every cycle until granted.
  - A slot in DONE blocks new issue to its unit, which raises execute_stall.
- Back-to-back issue:
  - ALU with LAT_ALU = 1 accepts one op every cycle while it keeps winning arbitration.
- ex_fu_busy[x] = slot state != IDLE.
- Tags with regdest 0 are tracked normally; filtering is the scoreboard's responsibility.

Decomposition:
- Shared package (ex_pkg):
  - unit codes FU_NONE = 00, FU_ALU = 01, FU_MEM = 10, FU_MUL = 11.
  - slot state encoding IDLE / RUN / DONE.
  - CNT_W = 4.
- Sub-module fu_slot, instantiated three times with its LAT parameter:
  - Contains the counter, state register and tag register.
  - Exports a req signal and a can_accept signal.
- The top level holds the arbiter and the stall/start logic.

Test Plan:
- Single op: ALU op, regdest 5, issued in cycle 10 -> ex_fu_start[0] high in cycle 11; ex_wb_valid high with regdest 5, unit 01 in cycle 11; no stall.
- Back-to-back ALU: ALU ops with regdest 1, 2, 3 in cycles 0-2 -> writebacks of 1, 2, 3 in cycles 1-3; execute_stall never asserted.
- Busy unit: MUL op regdest 7 in cycle 0, second MUL in cycle 1 ->
  - execute_stall held high in cycles 1-3.
  - regdest 7 written back in cycle 4, and the second MUL is accepted in cycle 4.
- Collision: MEM regdest 4 issued in cycle 0 and ALU regdest 9 in cycle 1, both completing in cycle 2 ->
  - cycle 2 grants 4 (MEM); ALU goes to DONE.
  - cycle 3 grants 9; an ALU issue in cycle 2 sees execute_stall = 1.
- Store: MEM op with writereg = 0 in cycle 0 -> no ex_wb_valid; ex_fu_busy[1] drops after cycle 2; a MEM op in cycle 2 is accepted.
- Reset mid-run: MUL in flight, reset pulsed in cycle 2 -> all outputs 0 immediately; no writeback of the in-flight tag ever appears.
